turf_acknack_mport: RTL and testbench

TURF_ACKNACK_MPORT -- requirements
Module: turf_acknack_mport

---
 rtl/turf_acknack_mport_pkg.sv | 26 ++
 rtl/turf_acknack_mport_if.sv | 63 ++++++
 rtl/turf_acknack_mport_hist.sv | 57 +++++
 rtl/turf_acknack_mport.sv | 157 +++++++++++++++
 tb/tb_turf_acknack_mport.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/turf_acknack_mport_pkg.sv
// ---------------------------------------------------------------------------
// turf_acknack_mport_pkg
// Shared definitions for the acknack multi-port block: controller state
// encoding, reply length, position of the OPEN flag in the echoed word and
// the width of the per-packet statistics counters.
// ---------------------------------------------------------------------------
package turf_acknack_mport_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_EMIT,
    ST_SKIP,
    ST_DUMP,
    ST_WR_HDR,
    ST_WR_W0,
    ST_WR_W1
  } state_t;

  // Reply payload is always two 64-bit words plus an 8-byte UDP header.
  localparam logic [15:0] REPLY_LEN = 16'd24;
  localparam int          OPEN_BIT  = 62;
  localparam int          CNT_W     = 16;

endpackage

// File: rtl/turf_acknack_mport_if.sv
// ---------------------------------------------------------------------------
// turf_acknack_mport_if
// Bundles the five streams of the acknack block:
//   s_udphdr   : request header  {ip[63:32], port[31:16], len[15:0]}
//   s_udpdata  : request payload (64-bit words with tkeep/tlast)
//   m_udphdr   : reply header    {ip, port, 16'd24}
//   m_udpdata  : reply payload   (two words, tkeep always 8'hFF)
//   m_acknack  : 16-bit ack/nack toward the frame buffer
// Modport slave is the block itself; modport master is its environment.
// ---------------------------------------------------------------------------
interface turf_acknack_mport_if;

  logic [63:0] s_udphdr_tdata;
  logic        s_udphdr_tvalid;
  logic        s_udphdr_tready;

  logic [63:0] s_udpdata_tdata;
  logic [7:0]  s_udpdata_tkeep;
  logic        s_udpdata_tlast;
  logic        s_udpdata_tvalid;
  logic        s_udpdata_tready;

  logic [63:0] m_udphdr_tdata;
  logic        m_udphdr_tvalid;
  logic        m_udphdr_tready;

  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tlast;
  logic        m_udpdata_tvalid;
  logic        m_udpdata_tready;

  logic [15:0] m_acknack_tdata;
  logic        m_acknack_tvalid;
  logic        m_acknack_tready;

  modport slave (
    input  s_udphdr_tdata, s_udphdr_tvalid,
    output s_udphdr_tready,
    input  s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid,
    output s_udpdata_tready,
    output m_udphdr_tdata, m_udphdr_tvalid,
    input  m_udphdr_tready,
    output m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
    input  m_udpdata_tready,
    output m_acknack_tdata, m_acknack_tvalid,
    input  m_acknack_tready
  );

  modport master (
    output s_udphdr_tdata, s_udphdr_tvalid,
    input  s_udphdr_tready,
    output s_udpdata_tdata, s_udpdata_tkeep, s_udpdata_tlast, s_udpdata_tvalid,
    input  s_udpdata_tready,
    input  m_udphdr_tdata, m_udphdr_tvalid,
    output m_udphdr_tready,
    input  m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, m_udpdata_tvalid,
    output m_udpdata_tready,
    input  m_acknack_tdata, m_acknack_tvalid,
    output m_acknack_tready
  );

endinterface

// File: rtl/turf_acknack_mport_hist.sv
// ---------------------------------------------------------------------------
// turf_acknack_hist
// Small duplicate-detection history: HIST_DEPTH registered entries written
// round-robin (oldest overwritten), each with a valid bit.
//   aclk, aresetn : clock, synchronous active-low reset (valid bits, pointer)
//   clear         : drop all valid bits next cycle (pointer is kept)
//   push          : store push_data at the write pointer, mark it valid
//   cmp_data      : word compared against every valid entry in parallel
//   match         : combinational hit, same cycle as cmp_data
// ---------------------------------------------------------------------------
module turf_acknack_hist #(
  parameter int HIST_DEPTH = 4,
  parameter int WORD_W     = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic [WORD_W-1:0] cmp_data,
  output logic              match
);

  localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [WORD_W-1:0]     entry [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] valid;
  logic [PTR_W-1:0]      wr_ptr;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid  <= '0;
      wr_ptr <= '0;
    end else begin
      // A clear in the same cycle as a push wins: the window just closed.
      if (clear)
        valid <= '0;
      else if (push)
        valid[wr_ptr] <= 1'b1;
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(HIST_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      entry[wr_ptr] <= push_data;
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < HIST_DEPTH; i++)
      if (valid[i] && (entry[i] == cmp_data))
        match = 1'b1;
  end

endmodule

// File: rtl/turf_acknack_mport.sv
// ---------------------------------------------------------------------------
// turf_acknack_mport
// Reads acknack request packets word by word, forwards each new masked word
// as a 16-bit ack/nack (suppressing repeats seen in the recent history),
// then answers the requester with a two-word status reply.
//   aclk, aresetn : clock, synchronous active-low reset
//   event_open_i  : event window open; low stops acks and wipes the history
//   bus (slave)   : s_udphdr / s_udpdata in, m_udphdr / m_udpdata /
//                   m_acknack out (see turf_acknack_mport_if)
// Parameters: CHECK_BITS compare/echo mask (OPEN bit always cleared),
//             HIST_DEPTH history entries (1..16), MAX_ENTRIES acks per
//             packet (1..255).
// ---------------------------------------------------------------------------
module turf_acknack_mport
  import turf_acknack_mport_pkg::*;
#(
  parameter logic [63:0] CHECK_BITS  = 64'h800000FF_FFF00000,
  parameter int          HIST_DEPTH  = 4,
  parameter int          MAX_ENTRIES = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 event_open_i,
  turf_acknack_mport_if.slave  bus
);

  localparam logic [63:0] MASK = CHECK_BITS & ~(64'd1 << OPEN_BIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nxt;
  logic [31:0]      ip_r;
  logic [15:0]      port_r;
  logic [63:0]      m_word;
  logic [15:0]      ack_word;
  logic [7:0]       keep_r;
  logic             last_r;
  logic             first_r;
  logic [63:0]      last_m;
  logic [CNT_W-1:0] accepted, dup_cnt, skip_cnt;
  logic             hist_match;
  logic             hdr_hs, data_hs;
  logic             do_skip, do_dup, do_push;
  logic             unused_len;

  assign unused_len = ^bus.s_udphdr_tdata[15:0];

  assign hdr_hs  = bus.s_udphdr_tvalid && bus.s_udphdr_tready;
  assign data_hs = bus.s_udpdata_tvalid && bus.s_udpdata_tready;

  turf_acknack_hist #(
    .HIST_DEPTH (HIST_DEPTH),
    .WORD_W     (64)
  ) u_hist (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear     (!event_open_i),
    .push      (do_push),
    .push_data (m_word),
    .cmp_data  (m_word),
    .match     (hist_match)
  );

  always_comb begin
    state_nxt = state;
    do_skip   = 1'b0;
    do_dup    = 1'b0;
    do_push   = 1'b0;
    case (state)
      ST_IDLE:   if (hdr_hs) state_nxt = ST_READ;
      ST_READ:   if (data_hs) state_nxt = ST_EVAL;
      ST_EVAL: begin
        if (keep_r != 8'hFF) begin
          // A partial first beat means a malformed request: no reply at all.
          if (first_r) state_nxt = last_r ? ST_IDLE : ST_DUMP;
          else         state_nxt = last_r ? ST_WR_HDR : ST_SKIP;
        end else begin
          state_nxt = last_r ? ST_WR_HDR : ST_READ;
          if (!event_open_i || (accepted == CNT_W'(MAX_ENTRIES)))
            do_skip = 1'b1;
          else if (hist_match)
            do_dup = 1'b1;
          else
            state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: if (bus.m_acknack_tready) begin
        do_push   = 1'b1;
        state_nxt = last_r ? ST_WR_HDR : ST_READ;
      end
      ST_SKIP:   if (data_hs && bus.s_udpdata_tlast) state_nxt = ST_WR_HDR;
      ST_DUMP:   if (data_hs && bus.s_udpdata_tlast) state_nxt = ST_IDLE;
      ST_WR_HDR: if (bus.m_udphdr_tready)  state_nxt = ST_WR_W0;
      ST_WR_W0:  if (bus.m_udpdata_tready) state_nxt = ST_WR_W1;
      ST_WR_W1:  if (bus.m_udpdata_tready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      ip_r     <= '0;
      port_r   <= '0;
      last_m   <= '0;
      accepted <= '0;
      dup_cnt  <= '0;
      skip_cnt <= '0;
      first_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && hdr_hs) begin
        ip_r     <= bus.s_udphdr_tdata[63:32];
        port_r   <= bus.s_udphdr_tdata[31:16];
        accepted <= '0;
        dup_cnt  <= '0;
        skip_cnt <= '0;
        first_r  <= 1'b1;
      end
      if (state == ST_EVAL) first_r  <= 1'b0;
      if (do_skip)          skip_cnt <= sat_inc(skip_cnt);
      if (do_dup)           dup_cnt  <= sat_inc(dup_cnt);
      if (do_push) begin
        accepted <= sat_inc(accepted);
        last_m   <= m_word;
      end
    end
  end

  // The ack carries the beat's own low half-word (allow + frame address);
  // the mask only governs duplicate comparison and the echoed word.
  always_ff @(posedge aclk) begin
    if (state == ST_READ && data_hs) begin
      m_word   <= bus.s_udpdata_tdata & MASK;
      ack_word <= bus.s_udpdata_tdata[15:0];
      keep_r   <= bus.s_udpdata_tkeep;
      last_r   <= bus.s_udpdata_tlast;
    end
  end

  assign bus.s_udphdr_tready  = !aresetn || (state == ST_IDLE);
  assign bus.s_udpdata_tready = aresetn &&
                                (state == ST_READ || state == ST_SKIP || state == ST_DUMP);
  assign bus.m_acknack_tvalid = aresetn && (state == ST_EMIT);
  assign bus.m_acknack_tdata  = ack_word;
  assign bus.m_udphdr_tvalid  = aresetn && (state == ST_WR_HDR);
  assign bus.m_udphdr_tdata   = {ip_r, port_r, REPLY_LEN};
  assign bus.m_udpdata_tvalid = aresetn && (state == ST_WR_W0 || state == ST_WR_W1);
  assign bus.m_udpdata_tlast  = (state == ST_WR_W1);
  assign bus.m_udpdata_tkeep  = 8'hFF;
  assign bus.m_udpdata_tdata  = (state == ST_WR_W1)
                              ? {accepted, dup_cnt, skip_cnt, 16'h0}
                              : (last_m | ({63'd0, event_open_i} << OPEN_BIT));

endmodule

// File: tb/tb_turf_acknack_mport.sv
// ---------------------------------------------------------------------------
// tb_turf_acknack_mport
// Directed bench for turf_acknack_mport (HIST_DEPTH=4, MAX_ENTRIES=2).
// A table of request packets with hand-computed acks and reply words is
// applied in a loop; malformed-packet and reset corner cases follow as
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_turf_acknack_mport;

  logic aclk       = 1'b0;
  logic aresetn    = 1'b0;
  logic event_open = 1'b0;
  bit   ack_tog    = 1'b0;

  turf_acknack_mport_if bus ();

  turf_acknack_mport #(
    .CHECK_BITS  (64'h800000FF_FFF00000),
    .HIST_DEPTH  (4),
    .MAX_ENTRIES (2)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .event_open_i (event_open),
    .bus          (bus)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reply / ack monitor, sampled on the falling edge.
  logic [15:0] ackq[$];
  int          reply_cnt = 0;
  int          rbeat     = 0;
  logic [63:0] rhdr, rw0, rw1;
  logic [7:0]  rk0, rk1;
  logic        rl0, rl1;

  always @(negedge aclk) begin
    if (bus.m_acknack_tvalid && bus.m_acknack_tready)
      ackq.push_back(bus.m_acknack_tdata);
    if (bus.m_udphdr_tvalid && bus.m_udphdr_tready) begin
      rhdr  <= bus.m_udphdr_tdata;
      rbeat <= 0;
    end
    if (bus.m_udpdata_tvalid && bus.m_udpdata_tready) begin
      if (rbeat == 0) begin
        rw0 <= bus.m_udpdata_tdata; rk0 <= bus.m_udpdata_tkeep; rl0 <= bus.m_udpdata_tlast;
      end else begin
        rw1 <= bus.m_udpdata_tdata; rk1 <= bus.m_udpdata_tkeep; rl1 <= bus.m_udpdata_tlast;
        reply_cnt <= reply_cnt + 1;
      end
      rbeat <= rbeat + 1;
    end
  end

  initial forever begin
    @(posedge aclk); #1;
    if (ack_tog) bus.m_acknack_tready = ~bus.m_acknack_tready;
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic send_hdr(input logic [63:0] d);
    bit done = 0;
    bus.s_udphdr_tdata  = d;
    bus.s_udphdr_tvalid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge aclk);
      done = bus.s_udphdr_tready;
      tick();
    end
    bus.s_udphdr_tvalid = 1'b0;
    if (!done) timeout("hdr_handshake");
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit done = 0;
    bus.s_udpdata_tdata  = d;
    bus.s_udpdata_tkeep  = k;
    bus.s_udpdata_tlast  = l;
    bus.s_udpdata_tvalid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge aclk);
      done = bus.s_udpdata_tready;
      tick();
    end
    bus.s_udpdata_tvalid = 1'b0;
    if (!done) timeout("beat_handshake");
  endtask

  typedef struct {
    int                n;
    bit                clr;
    bit                open;
    bit                tog;
    logic [0:3][63:0]  w;
    logic [0:3][7:0]   keep;
    int                n_ack;
    logic [0:3][15:0]  ack;
    logic [63:0]       w0;
    logic [63:0]       w1;
  } vec_t;

  function automatic vec_t mkv(int n, bit clr, bit open, bit tog,
                               logic [0:3][63:0] w, logic [0:3][7:0] k,
                               int na, logic [0:3][15:0] a,
                               logic [63:0] w0, logic [63:0] w1);
    vec_t v;
    v.n = n; v.clr = clr; v.open = open; v.tog = tog; v.w = w; v.keep = k;
    v.n_ack = na; v.ack = a; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  vec_t vecs[13];

  task automatic apply_vec(input int idx);
    vec_t        v = vecs[idx];
    int          base;
    bit          got = 0;
    logic [31:0] ip   = 32'h0A00_0000 + 32'(idx);
    logic [15:0] port = 16'h2000 + 16'(idx);
    if (v.clr) begin event_open = 1'b0; tick(); tick(); end
    event_open = v.open;
    ack_tog    = v.tog;
    if (!v.tog) bus.m_acknack_tready = 1'b1;
    ackq.delete();
    base = reply_cnt;
    send_hdr({ip, port, 16'(8 * v.n)});
    for (int i = 0; i < v.n; i++) send_beat(v.w[i], v.keep[i], i == v.n - 1);
    for (int c = 0; c < 300 && !got; c++) begin
      got = (reply_cnt != base);
      if (!got) tick();
    end
    ack_tog = 1'b0;
    bus.m_acknack_tready = 1'b1;
    if (!got) timeout($sformatf("v%0d_reply", idx));
    check($sformatf("v%0d_ack_count", idx), 64'(ackq.size()), 64'(v.n_ack));
    for (int i = 0; i < v.n_ack && i < ackq.size(); i++)
      check($sformatf("v%0d_ack%0d", idx, i), 64'(ackq[i]), 64'(v.ack[i]));
    check($sformatf("v%0d_hdr", idx), rhdr, {ip, port, 16'd24});
    check($sformatf("v%0d_word0", idx), rw0, v.w0);
    check($sformatf("v%0d_word1", idx), rw1, v.w1);
    check($sformatf("v%0d_keep_last", idx), {rk0, rk1, 6'd0, rl0, rl1}, {16'hFFFF, 8'h01});
    tick();
    check($sformatf("v%0d_idle", idx), 64'(bus.s_udphdr_tready), 64'd1);
  endtask

  localparam logic [63:0] WA = 64'h00000000_10000001, WB = 64'h00000000_20000002;
  localparam logic [63:0] WC = 64'h00000000_30000003, WD = 64'h00000000_40000004;
  localparam logic [63:0] WE = 64'h00000000_50000005, WQ = 64'h00000077_00000099;
  localparam logic [31:0] KF = 32'hFFFF_FFFF;

  initial begin
    int base;
    bus.s_udphdr_tvalid  = 1'b0;
    bus.s_udphdr_tdata   = '0;
    bus.s_udpdata_tvalid = 1'b0;
    bus.s_udpdata_tdata  = '0;
    bus.s_udpdata_tkeep  = '0;
    bus.s_udpdata_tlast  = 1'b0;
    bus.m_udphdr_tready  = 1'b1;
    bus.m_udpdata_tready = 1'b1;
    bus.m_acknack_tready = 1'b1;

    vecs[0]  = mkv(1, 1, 1, 0, {64'h800000AB_CDE00123, 192'd0}, KF, 1, {16'h0123, 48'd0},
                   64'hC00000AB_CDE00000, 64'h0001_0000_0000_0000);
    vecs[1]  = mkv(2, 0, 1, 0, {64'h00000011_22300456, 64'h00000011_22300456, 128'd0}, KF,
                   1, {16'h0456, 48'd0}, 64'h40000011_22300000, 64'h0001_0001_0000_0000);
    vecs[2]  = mkv(2, 1, 1, 0, {WA, WB, 128'd0}, KF, 2, {16'h0001, 16'h0002, 32'd0},
                   64'h40000000_20000000, 64'h0002_0000_0000_0000);
    vecs[3]  = mkv(2, 0, 1, 0, {WC, WD, 128'd0}, KF, 2, {16'h0003, 16'h0004, 32'd0},
                   64'h40000000_40000000, 64'h0002_0000_0000_0000);
    vecs[4]  = mkv(2, 0, 1, 0, {WE, WA, 128'd0}, KF, 2, {16'h0005, 16'h0001, 32'd0},
                   64'h40000000_10000000, 64'h0002_0000_0000_0000);
    vecs[5]  = mkv(1, 0, 1, 0, {WC, 192'd0}, KF, 0, 64'd0,
                   64'h40000000_10000000, 64'h0000_0001_0000_0000);
    vecs[6]  = mkv(3, 0, 0, 0, {64'h1, 64'h2, 64'h3, 64'd0}, KF, 0, 64'd0,
                   64'h00000000_10000000, 64'h0000_0000_0003_0000);
    vecs[7]  = mkv(4, 1, 1, 1, {64'h000000F0_00000011, 64'h000000F1_00000022,
                                64'h000000F2_00000033, 64'h000000F3_00000044}, KF,
                   2, {16'h0011, 16'h0022, 32'd0}, 64'h400000F1_00000000, 64'h0002_0000_0002_0000);
    vecs[8]  = mkv(3, 1, 1, 0, {64'h000000E0_00000077, 64'h00000000_0000DEAD,
                                64'h000000E5_00000000, 64'd0}, {8'hFF, 8'h0F, 8'hFF, 8'h00},
                   1, {16'h0077, 48'd0}, 64'h400000E0_00000000, 64'h0001_0000_0000_0000);
    vecs[9]  = mkv(1, 1, 1, 0, {WQ, 192'd0}, KF, 1, {16'h0099, 48'd0},
                   64'h40000077_00000000, 64'h0001_0000_0000_0000);
    vecs[10] = mkv(1, 0, 1, 0, {WQ, 192'd0}, KF, 0, 64'd0,
                   64'h40000077_00000000, 64'h0000_0001_0000_0000);
    vecs[11] = vecs[9];
    vecs[12] = mkv(1, 0, 1, 0, {WQ, 192'd0}, KF, 1, {16'h0099, 48'd0},
                   64'h40000077_00000000, 64'h0001_0000_0000_0000);

    repeat (3) tick();
    check("rst_hdr_tready",   64'(bus.s_udphdr_tready),  64'd1);
    check("rst_data_tready",  64'(bus.s_udpdata_tready), 64'd0);
    check("rst_valids",       64'({bus.m_udphdr_tvalid, bus.m_udpdata_tvalid, bus.m_acknack_tvalid}), 64'd0);
    aresetn    = 1'b1;
    event_open = 1'b1;
    tick();
    check("post_rst_hdr_tready", 64'(bus.s_udphdr_tready), 64'd1);

    for (int i = 0; i < 12; i++) apply_vec(i);

    // Partial first beat that is also the last: silently dropped.
    ackq.delete(); base = reply_cnt;
    send_hdr({32'h0B000001, 16'h3000, 16'd8});
    send_beat(64'h000000C1_00000055, 8'h0F, 1'b1);
    repeat (10) tick();
    check("dump1_acks",  64'(ackq.size()), 64'd0);
    check("dump1_reply", 64'(reply_cnt - base), 64'd0);
    check("dump1_idle",  64'(bus.s_udphdr_tready), 64'd1);

    // Partial first beat followed by a full last beat: drained, no reply.
    send_hdr({32'h0B000002, 16'h3001, 16'd16});
    send_beat(64'h000000C2_00000066, 8'h0F, 1'b0);
    send_beat(64'h000000C3_00000067, 8'hFF, 1'b1);
    repeat (10) tick();
    check("dump2_acks",  64'(ackq.size()), 64'd0);
    check("dump2_reply", 64'(reply_cnt - base), 64'd0);
    check("dump2_idle",  64'(bus.s_udphdr_tready), 64'd1);

    // Reset while an ack is pending: packet abandoned, no reply.
    bus.m_acknack_tready = 1'b0;
    send_hdr({32'h0B000003, 16'h3002, 16'd16});
    send_beat(64'h000000C4_00000088, 8'hFF, 1'b0);
    tick();
    aresetn = 1'b0;
    #1;
    check("midrst_hdr_tready", 64'(bus.s_udphdr_tready), 64'd1);
    check("midrst_valids", 64'({bus.m_acknack_tvalid, bus.s_udpdata_tready}), 64'd0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    bus.m_acknack_tready = 1'b1;
    repeat (5) tick();
    check("midrst_acks",  64'(ackq.size()), 64'd0);
    check("midrst_reply", 64'(reply_cnt - base), 64'd0);
    check("midrst_idle",  64'(bus.s_udphdr_tready), 64'd1);

    // History was wiped by reset, so a previously seen word is acked again.
    apply_vec(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
